// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution window scheduler.
// Holds the scheduler state encoding, kernel edge (KER), data width (DW)
// and the counter width (CW) used for row/column indices.
package cnn_pkg;

  localparam int unsigned KER = 3;
  localparam int unsigned DW  = 16;
  localparam int unsigned CW  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PRIME = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/conv_sched_if.sv
// Control/handshake bundle between conv_sched and its environment.
// master : scheduler side (drives fil_load, send, win_valid, win_row,
//          win_col, busy, done and, with CONV_SCHED_PERF_EN, stall_cnt)
// slave  : environment side (drives start, abort, pass, win_ready)
interface conv_sched_if;
  import cnn_pkg::*;

  logic          start;
  logic          abort;
  logic          fil_load;
  logic          send;
  logic          pass;
  logic          win_valid;
  logic          win_ready;
  logic [CW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          busy;
  logic          done;
`ifdef CONV_SCHED_PERF_EN
  logic [DW-1:0] stall_cnt;
`endif

  modport master (
    input  start, abort, pass, win_ready,
`ifdef CONV_SCHED_PERF_EN
    output stall_cnt,
`endif
    output fil_load, send, win_valid, win_row, win_col, busy, done
  );

  modport slave (
    output start, abort, pass, win_ready,
`ifdef CONV_SCHED_PERF_EN
    input  stall_cnt,
`endif
    input  fil_load, send, win_valid, win_row, win_col, busy, done
  );

endinterface

// File: rtl/conv_sched_cnt.sv
// Modulo-MOD up counter with synchronous clear and enable.
// Ports: clk, rst (async, active-high), en (count), clr (clear, wins over en),
//        cnt (current value), wrap_c (en while cnt == MOD-1, combinational).
module conv_sched_cnt
  import cnn_pkg::*;
#(
  parameter int unsigned MOD = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          wrap_c
);

  assign wrap_c = en && (cnt == CW'(MOD - 1));

  // Counter register: clear has priority, wrap returns to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap_c ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/conv_sched.sv
// Convolution sweep scheduler: loads the filter, primes two columns per
// output row, then emits one 3x3 window per accepted column advance.
// Ports: clk, rst_n (async, active-HIGH despite the name),
//        bus (conv_sched_if.master: start, abort, fil_load, send, pass,
//        win_valid, win_ready, win_row, win_col, busy, done).
// Optional: CONV_SCHED_PERF_EN adds bus.stall_cnt (saturating count of
//           cycles with win_valid=1 and win_ready=0).
module conv_sched
  import cnn_pkg::*;
#(
  parameter int unsigned IMG = 14,
  parameter int unsigned PAD = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  conv_sched_if.master bus
);

  localparam int unsigned SIZE = IMG + 2 * PAD;
  localparam int unsigned OUT  = SIZE - (KER - 1);

  state_t        state;
  logic          row_sent;
  logic [CW-1:0] col_cnt;
  logic [CW-1:0] row_cnt;
  logic          col_wrap_c;
  logic          row_wrap_c;
  logic          step_c;
  logic          take_c;
  logic          last_take_c;
  logic          cnt_clr_c;

  // send is decoded from registered state plus win_ready so that a stalled
  // window blocks the next column in the same cycle, while a consumed one
  // lets the next column go out immediately.
  assign bus.send = (state == PRIME) ||
                    ((state == RUN) && !row_sent && !(bus.win_valid && !bus.win_ready));

  assign step_c      = bus.send && bus.pass;
  assign take_c      = bus.win_valid && bus.win_ready;
  assign last_take_c = (state == RUN) && take_c && row_sent;
  assign cnt_clr_c   = bus.abort || (state == LOAD);

  conv_sched_cnt #(.MOD(SIZE)) u_col (
    .clk    (clk),
    .rst    (rst_n),
    .en     (step_c),
    .clr    (cnt_clr_c),
    .cnt    (col_cnt),
    .wrap_c (col_wrap_c)
  );

  conv_sched_cnt #(.MOD(OUT)) u_row (
    .clk    (clk),
    .rst    (rst_n),
    .en     (last_take_c),
    .clr    (cnt_clr_c),
    .cnt    (row_cnt),
    .wrap_c (row_wrap_c)
  );

  // Sweep FSM with registered outputs; abort overrides everything.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state         <= IDLE;
      row_sent      <= 1'b0;
      bus.fil_load  <= 1'b0;
      bus.win_valid <= 1'b0;
      bus.win_row   <= '0;
      bus.win_col   <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else if (bus.abort) begin
      state         <= IDLE;
      row_sent      <= 1'b0;
      bus.fil_load  <= 1'b0;
      bus.win_valid <= 1'b0;
      bus.win_row   <= '0;
      bus.win_col   <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.fil_load <= 1'b0;
      bus.done     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= LOAD;
            bus.fil_load <= 1'b1;
            bus.busy     <= 1'b1;
          end
        end
        LOAD: begin
          state    <= PRIME;
          row_sent <= 1'b0;
        end
        PRIME: begin
          // Columns 0 and 1 only fill the window; the third column starts RUN.
          if (step_c && (col_cnt == CW'(1))) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (take_c) begin
            bus.win_valid <= 1'b0;
          end
          if (step_c) begin
            bus.win_valid <= 1'b1;
            bus.win_row   <= row_cnt;
            bus.win_col   <= col_cnt - CW'(2);
            if (col_wrap_c) begin
              row_sent <= 1'b1;
            end
          end
          if (last_take_c) begin
            row_sent <= 1'b0;
            if (row_wrap_c) begin
              state    <= DONE;
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
            end else begin
              state <= PRIME;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CONV_SCHED_PERF_EN
  // Backpressure counter, restarted by each accepted start.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      bus.stall_cnt <= '0;
    end else if (bus.start && (state == IDLE)) begin
      bus.stall_cnt <= '0;
    end else if (bus.win_valid && !bus.win_ready && (bus.stall_cnt != '1)) begin
      bus.stall_cnt <= bus.stall_cnt + DW'(1);
    end
  end
`endif

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 SHALL have parameter IMG, default 14, meaning image edge length in pixels.
REQ-002 SHALL have parameter PAD, default 0, meaning zero-pad width per side; SIZE=IMG+2*PAD, OUT=SIZE-2.
REQ-003 SHALL have port clk  input  1  meaning sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, asynchronous, active-high (asserted=1) despite the name.
REQ-005 SHALL have port start  input  1  meaning one-cycle request to begin a full convolution sweep.
REQ-006 SHALL have port abort  input  1  meaning cancel the sweep in progress.
REQ-007 SHALL have port fil_load  output  1  meaning one-cycle strobe telling the window datapath to latch the 3x3 filter.
REQ-008 SHALL have port send  output  1  meaning request the datapath to advance one image column.
REQ-009 SHALL have port pass  input  1  meaning datapath acknowledges one column advance; counted only when send=1 in the same cycle.
REQ-010 SHALL have port win_valid  output  1  meaning a complete 3x3 window is present at the datapath outputs.
REQ-011 SHALL have port win_ready  input  1  meaning the downstream MAC accepts the window.
REQ-012 SHALL have port win_row  output  8  meaning output-map row of the current window.
REQ-013 SHALL have port win_col  output  8  meaning output-map column of the current window.
REQ-014 SHALL have port busy  output  1  meaning sweep in progress.
REQ-015 SHALL have port done  output  1  meaning one-cycle pulse after the final window is accepted.

Function
REQ-016 SHALL implement states IDLE, LOAD, PRIME, RUN, DONE.
REQ-017 IDLE: start=1 SHALL move to LOAD; start in any other state SHALL be ignored.
REQ-018 LOAD SHALL last exactly one cycle with fil_load=1, then move to PRIME with col_cnt=0, row=0.
REQ-019 PRIME SHALL assert send and count 2 accepted passes (columns 0,1), producing no window, then move to RUN.
REQ-020 RUN: each accepted pass SHALL register win_valid=1 on the next edge with win_row=row, win_col=col_cnt-2.
REQ-021 While win_valid=1 and win_ready=0, send SHALL be 0 and win_row/win_col SHALL hold.
REQ-022 A window SHALL be consumed on the edge with win_valid=1 and win_ready=1; send may reassert in that same cycle (one window per cycle sustained).
REQ-023 After the window with win_col=OUT-1 is consumed, row SHALL increment, col_cnt SHALL clear, and the FSM SHALL re-enter PRIME.
REQ-024 After window (OUT-1, OUT-1) is consumed, the FSM SHALL enter DONE, pulse done for one cycle, then return to IDLE.
REQ-025 busy SHALL be 1 in LOAD, PRIME, RUN and 0 in IDLE and DONE.
REQ-026 abort=1 SHALL force IDLE on the next edge, clearing send, win_valid and counters, from any state, with priority over all other inputs; no done pulse.
REQ-027 Counters SHALL be sized for SIZE up to 255; win_row/win_col SHALL never exceed OUT-1.

Reset
REQ-028 rst_n=1 SHALL asynchronously force IDLE and all outputs (fil_load, send, win_valid, win_row, win_col, busy, done) to 0, including mid-sweep.
REQ-029 After release, the first start SHALL begin at window (0,0).

Configuration
REQ-030 With CONV_SCHED_PERF_EN defined, the block SHALL add output stall_cnt [15:0], counting cycles with win_valid=1 and win_ready=0, saturating at 16'hFFFF and cleared by reset or start; without the macro, the port and logic SHALL be absent.

Structure
REQ-031 The state encoding, KER=3, and DW=16 SHALL reside in the shared package cnn_pkg.
REQ-032 One sub-module, conv_sched_cnt (modulo counter with enable, clear, and wrap flag), SHALL implement the column and row counters.

Verification
REQ-033 IMG=14, PAD=0, pass=send, win_ready=1 -> 144 windows, (0,0) first and (11,11) last, 168 accepted passes, one done pulse.
REQ-034 IMG=14, PAD=1 -> 196 windows, last (13,13), 224 accepted passes.
REQ-035 win_ready=0 for 5 cycles at window (0,3) -> (0,3) held, send=0 for 5 cycles, no window lost or duplicated; stall_cnt=5 with CONV_SCHED_PERF_EN.
REQ-036 abort at window (4,7) -> IDLE next cycle, busy=0, no done; next start restarts at (0,0).
REQ-037 start during RUN -> ignored, sequence unchanged.
REQ-038 rst_n=1 mid-RUN -> all outputs 0 immediately without a clock edge; the next sweep is complete and correct.
